// File: rtl/delay_sweep_if.sv
// delay_sweep_if: start/abort/SYNC controls, sweep configuration and status of the delay sweeper.
interface delay_sweep_if #(
  parameter int DW = 32,
  parameter int SW = 16,
  parameter int CW = 8
);
  logic          start;
  logic          abort;
  logic          sync_in;
  logic [DW-1:0] del_start;
  logic [DW-1:0] del_step;
  logic [SW-1:0] n_steps;
  logic [CW-1:0] shots;
  logic [DW-1:0] delay_out;
  logic [SW-1:0] step_idx;
  logic          busy;
  logic          done;
  logic          step_strobe;

  modport master (
    output start, abort, sync_in, del_start, del_step, n_steps, shots,
    input  delay_out, step_idx, busy, done, step_strobe
  );

  modport slave (
    input  start, abort, sync_in, del_start, del_step, n_steps, shots,
    output delay_out, step_idx, busy, done, step_strobe
  );
endinterface

// File: rtl/delay_sweep.sv
// delay_sweep: steps a pulse-generator delay through a programmed sweep, advancing on SYNC edges.
// Define DELAY_SWEEP_LOOP_EN to wrap back to del_start after the last step instead of finishing.
module delay_sweep #(
  parameter int DW = 32,
  parameter int SW = 16,
  parameter int CW = 8
) (
  input logic          clk_pll,
  input logic          reset,
  delay_sweep_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t        state;
  logic          ready;
  logic          sync_q;
  logic          sync_edge;
  logic [DW-1:0] step_q;
  logic [SW-1:0] n_q;
  logic [CW-1:0] shots_q;
  logic [DW-1:0] delay_q;
  logic [SW-1:0] idx_q;
  logic [CW-1:0] shot_cnt;
  logic          busy_q;
  logic          done_q;
  logic          strobe_q;
  logic [CW-1:0] shots_eff;
  logic [CW-1:0] shot_next;
  logic [SW-1:0] last_idx;
  logic          shot_last;
  logic          step_last;
`ifdef DELAY_SWEEP_LOOP_EN
  logic [DW-1:0] start_q;
`endif

  // ready rises one edge after reset release, so a start seen on that first edge is dropped.
  always_ff @(posedge clk_pll or negedge reset) begin
    if (!reset) begin
      ready  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      ready  <= 1'b1;
      sync_q <= bus.sync_in;
    end
  end

  assign sync_edge = bus.sync_in & ~sync_q;
  assign shots_eff = (shots_q == '0) ? CW'(1) : shots_q;
  assign last_idx  = (n_q == '0) ? '0 : n_q - SW'(1);
  assign shot_next = shot_cnt + CW'(1);
  assign shot_last = (shot_next == shots_eff);
  assign step_last = (idx_q == last_idx);

  // The edge that leaves ARM is shot 1 of step 0, so ARM and RUN share the shot/step logic.
  always_ff @(posedge clk_pll or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      step_q   <= '0;
      n_q      <= '0;
      shots_q  <= '0;
      delay_q  <= '0;
      idx_q    <= '0;
      shot_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
`ifdef DELAY_SWEEP_LOOP_EN
      start_q  <= '0;
`endif
    end else begin
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ready && bus.start && !bus.abort) begin
            step_q   <= bus.del_step;
            n_q      <= bus.n_steps;
            shots_q  <= bus.shots;
            delay_q  <= bus.del_start;
            idx_q    <= '0;
            shot_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= ARM;
`ifdef DELAY_SWEEP_LOOP_EN
            start_q  <= bus.del_start;
`endif
          end
        end
        ARM, RUN: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (sync_edge) begin
            state <= RUN;
            if (!shot_last) begin
              shot_cnt <= shot_next;
            end else begin
              shot_cnt <= '0;
              if (!step_last) begin
                idx_q    <= idx_q + SW'(1);
                delay_q  <= delay_q + step_q;
                strobe_q <= 1'b1;
              end else begin
`ifdef DELAY_SWEEP_LOOP_EN
                idx_q    <= '0;
                delay_q  <= start_q;
                strobe_q <= 1'b1;
`else
                done_q   <= 1'b1;
                state    <= DONE;
`endif
              end
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.delay_out   = delay_q;
  assign bus.step_idx    = idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.step_strobe = strobe_q;
endmodule

// File: doc/delay_sweep.md
DELAY_SWEEP -- requirements
Module: delay_sweep

Interface
REQ-001 Parameter DW, default 32, width of delay values and delay step.
REQ-002 Parameter SW, default 16, width of step count and step index.
REQ-003 Parameter CW, default 8, width of shots-per-step count.
REQ-004 clk_pll  input  1  PLL core clock; sole clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a sweep.
REQ-007 abort  input  1  one-cycle request to stop the sweep immediately.
REQ-008 sync_in  input  1  period SYNC pulse from the pulse generator, synchronous to clk_pll.
REQ-009 del_start  input  DW  first delay value, in clk_pll cycles.
REQ-010 del_step  input  DW  delay increment per step.
REQ-011 n_steps  input  SW  number of delay values in the sweep.
REQ-012 shots  input  CW  SYNC periods spent at each delay value.
REQ-013 delay_out  output  DW  registered delay driven into the pulse generator's delay input.
REQ-014 step_idx  output  SW  index of the current step, 0-based.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal sweep completion.
REQ-017 step_strobe  output  1  one-cycle pulse on each delay_out update after the first value.

Function
REQ-018 The FSM SHALL have four states: IDLE, ARM, RUN and DONE.
REQ-019 Sync edge SHALL be sync_in high with its one-cycle registered copy low; only this edge advances counters.
REQ-020 In IDLE, start SHALL latch del_step, n_steps and shots, load delay_out with del_start, clear step_idx and the shot counter, and enter ARM on the next cycle.
REQ-021 Configuration inputs SHALL be ignored outside the start cycle, and start SHALL be ignored while busy.
REQ-022 ARM SHALL enter RUN on the first sync edge, and that edge SHALL count as shot 1 of step 0.
REQ-023 In RUN, each sync edge SHALL increment the shot counter.
REQ-024 On the edge that completes shots periods, RUN SHALL clear the shot counter and then take one of two actions.
REQ-025 If step_idx is below n_steps-1, RUN SHALL increment step_idx, add del_step to delay_out (modulo 2^DW, carry discarded) and pulse step_strobe in the same cycle.
REQ-026 If step_idx equals n_steps-1, RUN SHALL enter DONE with no change to delay_out.
REQ-027 A latched shots value of 0 SHALL behave as 1, and a latched n_steps value of 0 SHALL behave as 1.
REQ-028 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-029 delay_out and step_idx SHALL hold their last values in IDLE.
REQ-030 abort SHALL have priority over sync edges and start.
REQ-031 abort in any non-IDLE state SHALL force IDLE on the next edge, hold delay_out and step_idx, and never assert done or step_strobe.
REQ-032 Latency from a qualifying sync edge (sync_in rising, registered) to the delay_out update SHALL be exactly 1 clk_pll cycle.

Reset
REQ-033 Asserting reset low SHALL asynchronously force state IDLE and clear delay_out, step_idx, the shot counter, busy, done, step_strobe and the sync register to 0.
REQ-034 Deassertion SHALL be synchronised to clk_pll, and the block SHALL ignore start in the first cycle after deassertion.

Configuration
REQ-035 The macro DELAY_SWEEP_LOOP_EN SHALL select end-of-sweep behaviour.
REQ-036 With DELAY_SWEEP_LOOP_EN defined, completing the last step SHALL reload delay_out with the latched del_start, clear step_idx, pulse step_strobe, stay in RUN, never assert done, and run until abort.
REQ-037 Without DELAY_SWEEP_LOOP_EN, the sweep SHALL end through DONE as in REQ-026 and REQ-028.
REQ-038 With DELAY_SWEEP_LOOP_EN defined, del_start SHALL additionally be latched at start.

Verification
REQ-039 Basic sweep: del_start=100, del_step=10, n_steps=3, shots=2, 6 sync edges -> delay_out 100,100,110,110,120,120; 2 step_strobes; done 1 cycle after 6th edge; busy low after.
REQ-040 Degenerate counts: n_steps=0, shots=0, one sync edge -> done after first edge, delay_out=del_start, no step_strobe.
REQ-041 Wrap: DW=32, del_start=32'hFFFF_FFF0, del_step=32'h20, n_steps=2, shots=1 -> second value 32'h0000_0010.
REQ-042 Abort and restart: abort in RUN at step_idx=1 with a sync edge in the same cycle -> IDLE, delay_out unchanged, no done; new start accepted the following cycle.
REQ-043 Loop build: build with DELAY_SWEEP_LOOP_EN, n_steps=2, shots=1, 5 edges -> delay_out del_start, +step, del_start, +step, del_start; done never asserted.
REQ-044 Reset mid-sweep: reset low during RUN -> all outputs 0 within the same cycle, asynchronously; start asserted during busy is ignored.
